// File: rtl/time_tx_pkg.sv
// Shared constants, state encodings and the binary-to-ASCII digit helper
// for the time-of-day UART transmitter.
package time_tx_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam int         MSG_LEN     = 10;

    typedef enum logic [1:0] {
        MSG_IDLE,
        MSG_LOAD,
        MSG_WAIT
    } msg_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } ser_state_e;

    typedef struct packed {
        logic [7:0] tens;
        logic [7:0] units;
    } ascii_pair_t;

    // Largest multiple of ten not above the value wins; covers 0..63 exactly.
    function automatic ascii_pair_t to_ascii_digits(input logic [5:0] value);
        ascii_pair_t result;
        logic [3:0]  tens_val;
        logic [5:0]  units_val;
        tens_val  = 4'd0;
        units_val = value;
        for (int k = 6; k >= 1; k--) begin
            if (tens_val == 4'd0 && value >= 6'(10 * k)) begin
                tens_val  = 4'(k);
                units_val = value - 6'(10 * k);
            end
        end
        result.tens  = ASCII_ZERO + {4'd0, tens_val};
        result.units = ASCII_ZERO + {2'd0, units_val};
        return result;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer. A start request in IDLE or in the last stop-bit cycle
// begins a frame on the next cycle; data must stay stable through the start bit.
module uart_byte_tx
    import time_tx_pkg::*;
#(
    parameter int BAUD_DIV = 1250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready,
    output logic       bit_done
);

    localparam int            CW        = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

    ser_state_e    state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          bit_end;

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        bit_end  = (baud_q == BAUD_LAST);
        bit_done = (state_q == TX_STOP) && bit_end;
        ready    = (state_q == TX_IDLE) || bit_done;

        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;

        if (state_q != TX_IDLE) begin
            baud_d = bit_end ? '0 : baud_q + CW'(1);
        end

        case (state_q)
            TX_IDLE: begin
                if (start) begin
                    state_d = TX_START;
                    baud_d  = '0;
                    tx_d    = 1'b0;
                end
            end
            TX_START: begin
                // Byte is captured at the end of the start bit.
                if (bit_end) begin
                    state_d = TX_DATA;
                    shift_d = data;
                    bit_d   = 3'd0;
                    tx_d    = data[0];
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            TX_STOP: begin
                // Chaining straight into the next start bit keeps bytes gap-free.
                if (bit_end) begin
                    if (start) begin
                        state_d = TX_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = TX_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign tx = tx_q;

endmodule

// File: rtl/time_uart_tx.sv
// Sends "HH:MM:SS\r\n" over UART on request, from a snapshot of the time
// taken at the accepting edge.
module time_uart_tx
    import time_tx_pkg::*;
#(
    parameter int BAUD_DIV = 1250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send,
    input  logic [5:0] hours,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

    msg_state_e  state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [5:0]  hrs_q, hrs_d;
    logic [5:0]  min_q, min_d;
    logic [5:0]  sec_q, sec_d;
    logic        done_q, done_d;

    logic        ser_start;
    logic        ser_ready;
    logic        ser_bit_done;
    logic [7:0]  cur_byte;
    ascii_pair_t hrs_asc, min_asc, sec_asc;

    always_comb begin
        hrs_asc = to_ascii_digits(hrs_q);
        min_asc = to_ascii_digits(min_q);
        sec_asc = to_ascii_digits(sec_q);
        cur_byte = ASCII_LF;
        case (idx_q)
            4'd0:    cur_byte = hrs_asc.tens;
            4'd1:    cur_byte = hrs_asc.units;
            4'd2:    cur_byte = ASCII_COLON;
            4'd3:    cur_byte = min_asc.tens;
            4'd4:    cur_byte = min_asc.units;
            4'd5:    cur_byte = ASCII_COLON;
            4'd6:    cur_byte = sec_asc.tens;
            4'd7:    cur_byte = sec_asc.units;
            4'd8:    cur_byte = ASCII_CR;
            default: cur_byte = ASCII_LF;
        endcase
    end

    // LOAD spans the first cycle of each start bit; the byte index already points
    // at the byte the serializer will capture at the end of that start bit.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        hrs_d     = hrs_q;
        min_d     = min_q;
        sec_d     = sec_q;
        done_d    = 1'b0;
        ser_start = 1'b0;

        case (state_q)
            MSG_IDLE: begin
                if (send && ser_ready) begin
                    ser_start = 1'b1;
                    hrs_d     = hours;
                    min_d     = minutes;
                    sec_d     = seconds;
                    idx_d     = 4'd0;
                    state_d   = MSG_LOAD;
                end
            end
            MSG_LOAD: begin
                state_d = MSG_WAIT;
            end
            MSG_WAIT: begin
                if (ser_bit_done) begin
                    if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        state_d = MSG_IDLE;
                    end else begin
                        idx_d     = idx_q + 4'd1;
                        ser_start = 1'b1;
                        state_d   = MSG_LOAD;
                    end
                end
            end
            default: begin
                state_d = MSG_IDLE;
            end
        endcase
    end

    // NOTE: asynchronous reset clears every register, snapshot included, so an aborted message leaves no residue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MSG_IDLE;
            idx_q   <= 4'd0;
            hrs_q   <= 6'd0;
            min_q   <= 6'd0;
            sec_q   <= 6'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hrs_q   <= hrs_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            done_q  <= done_d;
        end
    end

    uart_byte_tx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_byte_tx (
        .clk      (clk),
        .reset    (reset),
        .start    (ser_start),
        .data     (cur_byte),
        .tx       (tx),
        .ready    (ser_ready),
        .bit_done (ser_bit_done)
    );

    assign busy = (state_q != MSG_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_time_uart_tx.sv
// Directed bench for time_uart_tx at BAUD_DIV=4: decodes the serial line and
// compares against hand-computed byte tables and cycle positions.
module tb_time_uart_tx;

    localparam int BAUD       = 4;
    localparam int MSG_CYCLES = 100 * BAUD;

    logic       clk = 1'b0;
    logic       reset;
    logic       send;
    logic [5:0] hours, minutes, seconds;
    logic       tx, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    time_uart_tx #(.BAUD_DIV(BAUD)) dut (
        .clk     (clk),
        .reset   (reset),
        .send    (send),
        .hours   (hours),
        .minutes (minutes),
        .seconds (seconds),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Observes one message starting at the negedge of its first start-bit cycle
    // and returns at the negedge of the cycle right after the final stop bit.
    task automatic capture_msg(input int disturb_n, output logic [7:0] got [10],
                               output int frame_err, output int busy_low, output int done_seen);
        logic first_val;
        first_val = 1'b1;
        frame_err = 0;
        busy_low  = 0;
        done_seen = 0;
        for (int i = 0; i < 10; i++) got[i] = 8'h00;
        for (int n = 1; n <= MSG_CYCLES; n++) begin
            int p, bi, pos, c;
            p   = (n - 1) / BAUD;
            bi  = p / 10;
            pos = p % 10;
            c   = (n - 1) % BAUD;
            if (c == 0) first_val = tx;
            else if (tx !== first_val) frame_err++;
            if (pos == 0 && tx !== 1'b0) frame_err++;
            if (pos == 9 && tx !== 1'b1) frame_err++;
            if (pos >= 1 && pos <= 8 && c == 0) got[bi][3'(pos - 1)] = tx;
            if (busy !== 1'b1) busy_low++;
            if (done !== 1'b0) done_seen++;
            if (disturb_n != 0 && n == disturb_n) begin
                hours = 6'd1; minutes = 6'd2; seconds = 6'd3; send = 1'b1;
            end else if (disturb_n != 0 && n == disturb_n + 1) begin
                send = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b1; send = 1'b0;
        hours = 6'd0; minutes = 6'd0; seconds = 6'd0;
        repeat (3) @(negedge clk);
        n_cmp++; if (tx !== 1'b1)   begin n_err++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL reset_idle_hold: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_basic();
        logic [7:0] got [10];
        logic [7:0] exp_b [10];
        int fe, bl, ds;
        exp_b = '{8'h31, 8'h33, 8'h3A, 8'h30, 8'h35, 8'h3A, 8'h34, 8'h32, 8'h0D, 8'h0A};
        hours = 6'd13; minutes = 6'd5; seconds = 6'd42; send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        n_cmp++; if (tx !== 1'b0)   begin n_err++; $display("FAIL basic_first_start: tx got %b want 0", tx); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_first_busy: got %b want 1", busy); end
        capture_msg(0, got, fe, bl, ds);
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (got[i] !== exp_b[i]) begin n_err++; $display("FAIL basic_byte%0d: got %h want %h", i, got[i], exp_b[i]); end
        end
        n_cmp++; if (fe !== 0) begin n_err++; $display("FAIL basic_framing: got %0d errors want 0", fe); end
        n_cmp++; if (bl !== 0) begin n_err++; $display("FAIL basic_busy_gap: got %0d low cycles want 0", bl); end
        n_cmp++; if (ds !== 0) begin n_err++; $display("FAIL basic_done_early: got %0d want 0", ds); end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL basic_done_401: got %b want 1", done); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
        n_cmp++; if (tx !== 1'b1)   begin n_err++; $display("FAIL basic_tx_at_done: got %b want 1", tx); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_width: got %b want 0", done); end
        n_cmp++; if (tx !== 1'b1)   begin n_err++; $display("FAIL basic_tx_after: got %b want 1", tx); end
    endtask

    task automatic test_boundary();
        logic [7:0] got [10];
        logic [7:0] tab [3][10];
        logic [5:0] hv [3];
        logic [5:0] mv [3];
        logic [5:0] sv [3];
        int fe, bl, ds;
        tab = '{'{8'h30, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h0D, 8'h0A},
                '{8'h32, 8'h33, 8'h3A, 8'h35, 8'h39, 8'h3A, 8'h35, 8'h39, 8'h0D, 8'h0A},
                '{8'h36, 8'h33, 8'h3A, 8'h36, 8'h30, 8'h3A, 8'h30, 8'h39, 8'h0D, 8'h0A}};
        hv = '{6'd0, 6'd23, 6'd63};
        mv = '{6'd0, 6'd59, 6'd60};
        sv = '{6'd0, 6'd59, 6'd9};
        for (int v = 0; v < 3; v++) begin
            hours = hv[v]; minutes = mv[v]; seconds = sv[v]; send = 1'b1;
            @(negedge clk);
            send = 1'b0;
            capture_msg(0, got, fe, bl, ds);
            for (int i = 0; i < 10; i++) begin
                n_cmp++;
                if (got[i] !== tab[v][i]) begin
                    n_err++; $display("FAIL boundary%0d_byte%0d: got %h want %h", v, i, got[i], tab[v][i]);
                end
            end
            n_cmp++; if (fe !== 0 || bl !== 0 || ds !== 0) begin
                n_err++; $display("FAIL boundary%0d_frame: got fe=%0d bl=%0d ds=%0d want 0/0/0", v, fe, bl, ds);
            end
            n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL boundary%0d_done: got %b want 1", v, done); end
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_snapshot();
        logic [7:0] got [10];
        logic [7:0] exp_b [10];
        int fe, bl, ds, bad;
        exp_b = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36, 8'h0D, 8'h0A};
        hours = 6'd12; minutes = 6'd34; seconds = 6'd56; send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        capture_msg(3 * 10 * BAUD + 5, got, fe, bl, ds);
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (got[i] !== exp_b[i]) begin n_err++; $display("FAIL snapshot_byte%0d: got %h want %h", i, got[i], exp_b[i]); end
        end
        n_cmp++; if (bl !== 0) begin n_err++; $display("FAIL snapshot_busy_gap: got %0d low cycles want 0", bl); end
        n_cmp++; if (fe !== 0) begin n_err++; $display("FAIL snapshot_framing: got %0d errors want 0", fe); end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL snapshot_done: got %b want 1", done); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL snapshot_no_second_msg: got %0d active cycles want 0", bad); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] got [10];
        logic [7:0] exp_b [10];
        int fe, bl, ds, bad;
        exp_b = '{8'h30, 8'h37, 8'h3A, 8'h30, 8'h38, 8'h3A, 8'h30, 8'h39, 8'h0D, 8'h0A};
        hours = 6'd20; minutes = 6'd45; seconds = 6'd17; send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        bad = 0;
        for (int n = 1; n < 215; n++) begin
            if (done !== 1'b0 || busy !== 1'b1) bad++;
            @(negedge clk);
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL rstmid_pre_busy: got %0d bad cycles want 0", bad); end
        // Cycle 215 sits on bit 2 of the ':' in byte 5, which is a 0.
        n_cmp++; if (tx !== 1'b0) begin n_err++; $display("FAIL rstmid_pre_tx: got %b want 0", tx); end
        reset = 1'b1;
        #1;
        n_cmp++; if (tx !== 1'b1)   begin n_err++; $display("FAIL rstmid_tx_now: got %b want 1", tx); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy_now: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rstmid_done_now: got %b want 0", done); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL rstmid_aborted: got %0d active cycles want 0", bad); end
        reset = 1'b1;
        hours = 6'd7; minutes = 6'd8; seconds = 6'd9; send = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || tx !== 1'b1) begin
            n_err++; $display("FAIL rstmid_send_in_reset: got busy=%b tx=%b want 0/1", busy, tx);
        end
        reset = 1'b0;
        @(negedge clk);
        send = 1'b0;
        capture_msg(0, got, fe, bl, ds);
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (got[i] !== exp_b[i]) begin n_err++; $display("FAIL rstmid_resend_byte%0d: got %h want %h", i, got[i], exp_b[i]); end
        end
        n_cmp++; if (fe !== 0 || bl !== 0 || ds !== 0) begin
            n_err++; $display("FAIL rstmid_resend_frame: got fe=%0d bl=%0d ds=%0d want 0/0/0", fe, bl, ds);
        end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL rstmid_resend_done: got %b want 1", done); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] got [10];
        logic [7:0] exp_a [10];
        logic [7:0] exp_b [10];
        int fe, bl, ds;
        exp_a = '{8'h31, 8'h30, 8'h3A, 8'h32, 8'h30, 8'h3A, 8'h33, 8'h30, 8'h0D, 8'h0A};
        exp_b = '{8'h30, 8'h39, 8'h3A, 8'h30, 8'h38, 8'h3A, 8'h30, 8'h37, 8'h0D, 8'h0A};
        hours = 6'd10; minutes = 6'd20; seconds = 6'd30; send = 1'b1;
        @(negedge clk);
        capture_msg(0, got, fe, bl, ds);
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (got[i] !== exp_a[i]) begin n_err++; $display("FAIL b2b_a_byte%0d: got %h want %h", i, got[i], exp_a[i]); end
        end
        n_cmp++; if (fe !== 0 || bl !== 0 || ds !== 0) begin
            n_err++; $display("FAIL b2b_a_frame: got fe=%0d bl=%0d ds=%0d want 0/0/0", fe, bl, ds);
        end
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL b2b_a_done: got done=%b busy=%b want 1/0", done, busy);
        end
        hours = 6'd9; minutes = 6'd8; seconds = 6'd7;
        @(negedge clk);
        n_cmp++; if (tx !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            n_err++; $display("FAIL b2b_restart: got tx=%b busy=%b done=%b want 0/1/0", tx, busy, done);
        end
        send = 1'b0;
        capture_msg(0, got, fe, bl, ds);
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (got[i] !== exp_b[i]) begin n_err++; $display("FAIL b2b_b_byte%0d: got %h want %h", i, got[i], exp_b[i]); end
        end
        n_cmp++; if (fe !== 0 || bl !== 0 || ds !== 0) begin
            n_err++; $display("FAIL b2b_b_frame: got fe=%0d bl=%0d ds=%0d want 0/0/0", fe, bl, ds);
        end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_b_done: got %b want 1", done); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL b2b_end_idle: got done=%b busy=%b want 0/0", done, busy);
        end
    endtask

    initial begin
        reset = 1'b1; send = 1'b0;
        hours = 6'd0; minutes = 6'd0; seconds = 6'd0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_boundary();
        test_snapshot();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/time_uart_tx.md
TIME_UART_TX -- requirements
Module: time_uart_tx

Interface
REQ-001 SHALL have parameter: BAUD_DIV, 1250, clk cycles per serial bit (12 MHz / 9600 baud); legal range 2..65535.
REQ-002 SHALL have port: clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: send  input  1  request to transmit the current time; sampled every clk edge.
REQ-005 SHALL have port: hours  input  6  binary hours from the clock block, 0..23 nominal.
REQ-006 SHALL have port: minutes  input  6  binary minutes, 0..59 nominal.
REQ-007 SHALL have port: seconds  input  6  binary seconds, 0..59 nominal.
REQ-008 SHALL have port: tx  output  1  UART serial line, idle high, 8N1 framing.
REQ-009 SHALL have port: busy  output  1  high while a message is in flight.
REQ-010 SHALL have port: done  output  1  one-cycle pulse when a message completes.

Function
REQ-011 SHALL transmit exactly 10 bytes per message, in order: H tens, H units, 0x3A, M tens, M units, 0x3A, S tens, S units, 0x0D, 0x0A.
REQ-012 SHALL encode each digit as 0x30 + digit; tens = value/10, units = value mod 10, exact for all 6-bit inputs 0..63 (60..63 give tens '6').
REQ-013 SHALL accept send only when busy is low; send while busy is ignored, with no queuing.
REQ-014 SHALL snapshot hours, minutes and seconds on the accepting edge; input changes after that edge do not alter the message in flight.
REQ-015 SHALL assert busy and drive the first start bit (tx=0) on the cycle after the accepting edge.
REQ-016 SHALL frame each byte as start bit 0, 8 data bits LSB first, stop bit 1; each bit held exactly BAUD_DIV cycles.
REQ-017 SHALL send bytes back-to-back with no idle gap: the next start bit begins on the cycle after the previous stop bit ends; a message therefore occupies exactly 100*BAUD_DIV cycles.
REQ-018 SHALL deassert busy and pulse done high for exactly one cycle on the first cycle after the final stop bit; tx remains 1 thereafter.
REQ-019 SHALL accept a send that is high during the done cycle, starting a new message with the same one-cycle latency.
REQ-020 SHALL use top FSM states IDLE, LOAD (select byte by index 0..9), WAIT (serializer active); transitions: IDLE->LOAD on accepted send, LOAD->WAIT, WAIT->LOAD when a byte completes and index<9, WAIT->IDLE after index 9.
REQ-021 SHALL use serializer states IDLE, START, DATA, STOP; a bit counter of 0..7 and a baud counter of $clog2(BAUD_DIV) bits, wrapping at BAUD_DIV-1.
REQ-022 SHALL register tx; no combinational path from any input to tx.

Reset
REQ-023 SHALL on reset force tx=1, busy=0, done=0, both FSMs to IDLE, and all counters, byte index and snapshot registers to 0.
REQ-024 SHALL on reset mid-message abort the message immediately, with no done pulse and no further bytes emitted.
REQ-025 SHALL ignore send while reset is asserted and accept it starting on the first edge after release.

Structure
REQ-026 SHALL place ASCII_ZERO (0x30), ASCII_COLON (0x3A), ASCII_CR (0x0D), ASCII_LF (0x0A), MSG_LEN (10) and both state enums in package time_tx_pkg.
REQ-027 SHALL implement 8N1 serialization in sub-module uart_byte_tx (ports clk, reset, start, data[7:0], tx, ready, bit_done) parameterised by BAUD_DIV; time_uart_tx handles message sequencing and digit conversion.
REQ-028 SHALL perform digit conversion combinationally from the snapshot registers using compare/subtract against 10..60, with no divider.

Verification (bench BAUD_DIV=4)
REQ-029 SHALL check reset: after reset, tx=1, busy=0, done=0; these hold indefinitely with send=0.
REQ-030 SHALL check input 13:05:42 with a 1-cycle send pulse: bytes 31 33 3A 30 35 3A 34 32 0D 0A decoded LSB-first, 4 cycles/bit; done pulses 401 cycles after the send edge.
REQ-031 SHALL check boundary inputs: 00:00:00 gives 30 30 3A 30 30 3A 30 30 0D 0A; 23:59:59 gives 32 33 3A 35 39 3A 35 39 0D 0A; hours=63 gives tens 0x36 and units 0x33.
REQ-032 SHALL check that changing the inputs and pulsing send during byte 3: the output is still the original snapshot, with no second message and busy continuous.
REQ-033 SHALL check that reset asserted during byte 5: tx=1 and busy=0 immediately with no done pulse; a later send transmits a full message correctly.
REQ-034 SHALL check that send held high through done: a second message starts on the cycle after done, with no idle gap beyond one cycle and both messages correct.
